// File: rtl/VX_kmu_pkg.sv
// -----------------------------------------------------------------------------
// VX_kmu_pkg
// Shared types for the KMU request bus and the launch generator.
//   kmu_req_data_t : one block descriptor as it travels on the bus (default
//                    widths); lanes are packed valid | bx | by | bz | pc | arg,
//                    with arg in the least significant bits.
//   kmu_state_e    : launch generator control states.
// -----------------------------------------------------------------------------
package VX_kmu_pkg;

  localparam int KMU_DIM_W = 16;
  localparam int KMU_PC_W  = 32;
  localparam int KMU_ARG_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [KMU_DIM_W-1:0] bx;
    logic [KMU_DIM_W-1:0] by;
    logic [KMU_DIM_W-1:0] bz;
    logic [KMU_PC_W-1:0]  pc;
    logic [KMU_ARG_W-1:0] arg;
  } kmu_req_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } kmu_state_e;

endpackage

// File: rtl/kmu_grid_step.sv
// -----------------------------------------------------------------------------
// kmu_grid_step
// Combinational x-fastest grid cursor advance.
//   cur_x/y/z  : current block coordinate (always inside the grid)
//   grid_x/y/z : grid dimensions
//   nxt_x/y/z  : coordinate of the following block, zero when there is none
//   last       : current coordinate is the final block of the grid
// -----------------------------------------------------------------------------
module kmu_grid_step #(
  parameter int DIM_W = 16
) (
  input  logic [DIM_W-1:0] cur_x,
  input  logic [DIM_W-1:0] cur_y,
  input  logic [DIM_W-1:0] cur_z,
  input  logic [DIM_W-1:0] grid_x,
  input  logic [DIM_W-1:0] grid_y,
  input  logic [DIM_W-1:0] grid_z,
  output logic [DIM_W-1:0] nxt_x,
  output logic [DIM_W-1:0] nxt_y,
  output logic [DIM_W-1:0] nxt_z,
  output logic             last
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1'b1);

  logic x_end_s;
  logic y_end_s;
  logic z_end_s;

  // Comparing against grid-1 keeps the arithmetic inside DIM_W bits even
  // for a full-range dimension.
  assign x_end_s = (cur_x == (grid_x - ONE));
  assign y_end_s = (cur_y == (grid_y - ONE));
  assign z_end_s = (cur_z == (grid_z - ONE));

  // Ripple the carry x -> y -> z; past the end the cursor parks at zero.
  always_comb begin
    nxt_x = '0;
    nxt_y = '0;
    nxt_z = '0;
    last  = 1'b0;
    if (x_end_s && y_end_s && z_end_s) begin
      last = 1'b1;
    end else if (x_end_s && y_end_s) begin
      nxt_z = cur_z + ONE;
    end else if (x_end_s) begin
      nxt_y = cur_y + ONE;
      nxt_z = cur_z;
    end else begin
      nxt_x = cur_x + ONE;
      nxt_y = cur_y;
      nxt_z = cur_z;
    end
  end

endmodule

// File: rtl/kmu_launch_gen.sv
// -----------------------------------------------------------------------------
// kmu_launch_gen
// Producer end of the KMU request bus. Takes one kernel-launch command and
// walks its grid x-fastest, emitting NUM_LANES block descriptors per beat.
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : launch command handshake (ready only in IDLE)
//   cmd_grid_x/y/z      : grid dimensions
//   cmd_pc, cmd_arg     : kernel entry PC and argument pointer
//   cancel              : stop after the next accepted beat
//   req_valid/req_ready : bus beat handshake
//   req_data            : lane i at [i*LW +: LW], LW = 1+3*DIM_W+PC_W+ARG_W
//   busy                : issuing beats
//   done                : one-cycle pulse at completion or cancel
// -----------------------------------------------------------------------------
module kmu_launch_gen
  import VX_kmu_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int DIM_W     = KMU_DIM_W,
  parameter int PC_W      = KMU_PC_W,
  parameter int ARG_W     = KMU_ARG_W
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        cmd_valid,
  output logic                                        cmd_ready,
  input  logic [DIM_W-1:0]                            cmd_grid_x,
  input  logic [DIM_W-1:0]                            cmd_grid_y,
  input  logic [DIM_W-1:0]                            cmd_grid_z,
  input  logic [PC_W-1:0]                             cmd_pc,
  input  logic [ARG_W-1:0]                            cmd_arg,
  input  logic                                        cancel,
  output logic                                        req_valid,
  output logic [NUM_LANES*(1+3*DIM_W+PC_W+ARG_W)-1:0] req_data,
  input  logic                                        req_ready,
  output logic                                        busy,
  output logic                                        done
);

  localparam int LW = 1 + 3*DIM_W + PC_W + ARG_W;
  localparam int BW = NUM_LANES * LW;

  kmu_state_e       state_r;
  kmu_state_e       state_nxt_s;

  logic [DIM_W-1:0] grid_x_r, grid_y_r, grid_z_r;
  logic [PC_W-1:0]  pc_r;
  logic [ARG_W-1:0] arg_r;
  logic [DIM_W-1:0] cur_x_r, cur_y_r, cur_z_r;

  logic [BW-1:0]    req_data_r;
  logic             req_valid_r;
  logic             last_beat_r;
  logic             cancel_pend_r;
  logic             done_r;
  logic             cmd_ready_r;
  logic             busy_r;

  logic [DIM_W-1:0] gx_s, gy_s, gz_s;
  logic [DIM_W-1:0] sx_s, sy_s, sz_s;
  logic [PC_W-1:0]  pc_s;
  logic [ARG_W-1:0] arg_s;

  logic [BW-1:0]    beat_s;
  logic             beat_last_s;
  logic [DIM_W-1:0] next_x_s, next_y_s, next_z_s;

  logic             zero_dim_s;
  logic             cmd_fire_s;
  logic             accept_s;
  logic             load_beat_s;
  logic             clear_beat_s;
  logic             issue_exit_s;
  logic             done_nxt_s;

  assign zero_dim_s = (cmd_grid_x == '0) | (cmd_grid_y == '0) | (cmd_grid_z == '0);
  assign cmd_fire_s = cmd_valid & cmd_ready_r & (state_r == IDLE);
  assign accept_s   = req_valid_r & req_ready;

  // In IDLE the first beat is built straight from the command so it can be
  // registered on the handshake edge; afterwards from the latched copy.
  always_comb begin
    if (state_r == IDLE) begin
      gx_s  = cmd_grid_x;
      gy_s  = cmd_grid_y;
      gz_s  = cmd_grid_z;
      pc_s  = cmd_pc;
      arg_s = cmd_arg;
      sx_s  = '0;
      sy_s  = '0;
      sz_s  = '0;
    end else begin
      gx_s  = grid_x_r;
      gy_s  = grid_y_r;
      gz_s  = grid_z_r;
      pc_s  = pc_r;
      arg_s = arg_r;
      sx_s  = cur_x_r;
      sy_s  = cur_y_r;
      sz_s  = cur_z_r;
    end
  end

  // Lane k sees the start cursor advanced k times; a lane stays valid only
  // while no earlier lane held the final block.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [DIM_W-1:0] in_x_s, in_y_s, in_z_s;
    logic [DIM_W-1:0] out_x_s, out_y_s, out_z_s;
    logic             in_v_s;
    logic             out_v_s;
    logic             last_s;

    if (k == 0) begin : g_head
      assign in_x_s = sx_s;
      assign in_y_s = sy_s;
      assign in_z_s = sz_s;
      assign in_v_s = 1'b1;
    end else begin : g_link
      assign in_x_s = g_lane[k-1].out_x_s;
      assign in_y_s = g_lane[k-1].out_y_s;
      assign in_z_s = g_lane[k-1].out_z_s;
      assign in_v_s = g_lane[k-1].out_v_s;
    end

    kmu_grid_step #(
      .DIM_W (DIM_W)
    ) u_step (
      .cur_x  (in_x_s),
      .cur_y  (in_y_s),
      .cur_z  (in_z_s),
      .grid_x (gx_s),
      .grid_y (gy_s),
      .grid_z (gz_s),
      .nxt_x  (out_x_s),
      .nxt_y  (out_y_s),
      .nxt_z  (out_z_s),
      .last   (last_s)
    );

    assign out_v_s = in_v_s & ~last_s;
    assign beat_s[k*LW +: LW] = in_v_s ? {1'b1, in_x_s, in_y_s, in_z_s, pc_s, arg_s}
                                       : {LW{1'b0}};
  end

  // The cursor after the last lane is where the next beat starts; if it is
  // no longer valid this beat carries the final block.
  assign beat_last_s = ~g_lane[NUM_LANES-1].out_v_s;
  assign next_x_s    = g_lane[NUM_LANES-1].out_x_s;
  assign next_y_s    = g_lane[NUM_LANES-1].out_y_s;
  assign next_z_s    = g_lane[NUM_LANES-1].out_z_s;

  // Next-state and beat-register control.
  always_comb begin
    state_nxt_s  = state_r;
    load_beat_s  = 1'b0;
    clear_beat_s = 1'b0;
    issue_exit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          if (zero_dim_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ISSUE;
            load_beat_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (accept_s) begin
          if (last_beat_r || cancel_pend_r || cancel) begin
            state_nxt_s  = DONE;
            clear_beat_s = 1'b1;
            issue_exit_s = 1'b1;
          end else begin
            load_beat_s  = 1'b1;
          end
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // A finished run pulses done on its exit edge; a zero-sized launch spends
  // one cycle in DONE first, so its pulse lands two cycles after the command.
  assign done_nxt_s = issue_exit_s | ((state_r == DONE) & ~done_r);

  // Control state, command latch and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      grid_x_r      <= '0;
      grid_y_r      <= '0;
      grid_z_r      <= '0;
      pc_r          <= '0;
      arg_r         <= '0;
      cancel_pend_r <= 1'b0;
      done_r        <= 1'b0;
      cmd_ready_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      done_r        <= done_nxt_s;
      cmd_ready_r   <= (state_nxt_s == IDLE) & ~done_nxt_s;
      busy_r        <= (state_nxt_s == ISSUE);
      cancel_pend_r <= (state_nxt_s == ISSUE) &
                       (cancel_pend_r | ((state_r == ISSUE) & cancel));
      if (cmd_fire_s) begin
        grid_x_r <= cmd_grid_x;
        grid_y_r <= cmd_grid_y;
        grid_z_r <= cmd_grid_z;
        pc_r     <= cmd_pc;
        arg_r    <= cmd_arg;
      end
    end
  end

  // Beat register and cursor: held while stalled, reloaded on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_data_r  <= '0;
      req_valid_r <= 1'b0;
      last_beat_r <= 1'b0;
      cur_x_r     <= '0;
      cur_y_r     <= '0;
      cur_z_r     <= '0;
    end else if (load_beat_s) begin
      req_data_r  <= beat_s;
      req_valid_r <= 1'b1;
      last_beat_r <= beat_last_s;
      cur_x_r     <= beat_last_s ? '0 : next_x_s;
      cur_y_r     <= beat_last_s ? '0 : next_y_s;
      cur_z_r     <= beat_last_s ? '0 : next_z_s;
    end else if (clear_beat_s) begin
      req_data_r  <= '0;
      req_valid_r <= 1'b0;
      last_beat_r <= 1'b0;
      cur_x_r     <= '0;
      cur_y_r     <= '0;
      cur_z_r     <= '0;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign req_valid = req_valid_r;
  assign req_data  = req_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_kmu_launch_gen.sv
// -----------------------------------------------------------------------------
// tb_kmu_launch_gen
// Directed bench for kmu_launch_gen: one single-lane instance (a_*) and one
// four-lane instance (b_*) sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_kmu_launch_gen;

  localparam int LW = 113;

  logic clk;
  logic rst_n;

  logic          a_cmd_valid, a_cmd_ready, a_cancel, a_req_valid, a_req_ready, a_busy, a_done;
  logic [15:0]   a_gx, a_gy, a_gz;
  logic [31:0]   a_pc, a_arg;
  logic [LW-1:0] a_req_data;

  logic            b_cmd_valid, b_cmd_ready, b_cancel, b_req_valid, b_req_ready, b_busy, b_done;
  logic [15:0]     b_gx, b_gy, b_gz;
  logic [31:0]     b_pc, b_arg;
  logic [4*LW-1:0] b_req_data;

  int vec_cnt;
  int err_cnt;

  kmu_launch_gen #(.NUM_LANES(1)) dut_a (
    .clk(clk), .reset(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_grid_x(a_gx), .cmd_grid_y(a_gy), .cmd_grid_z(a_gz), .cmd_pc(a_pc), .cmd_arg(a_arg),
    .cancel(a_cancel), .req_valid(a_req_valid), .req_data(a_req_data), .req_ready(a_req_ready),
    .busy(a_busy), .done(a_done)
  );

  kmu_launch_gen #(.NUM_LANES(4)) dut_b (
    .clk(clk), .reset(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_grid_x(b_gx), .cmd_grid_y(b_gy), .cmd_grid_z(b_gz), .cmd_pc(b_pc), .cmd_arg(b_arg),
    .cancel(b_cancel), .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] mk(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z, input logic [31:0] pc,
                                       input logic [31:0] arg);
    return {1'b1, x, y, z, pc, arg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch_a(input logic [15:0] gx, input logic [15:0] gy, input logic [15:0] gz,
                          input logic [31:0] pc, input logic [31:0] arg);
    a_cmd_valid = 1'b1; a_gx = gx; a_gy = gy; a_gz = gz; a_pc = pc; a_arg = arg;
    tick();
    a_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (a_cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_ready: got %b want 0", a_cmd_ready); end
    vec_cnt++; if (a_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_req_valid: got %b want 0", a_req_valid); end
    vec_cnt++; if (a_req_data !== '0) begin err_cnt++; $display("FAIL rst_req_data: got %h want 0", a_req_data); end
    vec_cnt++; if ({a_busy, a_done} !== 2'b00) begin err_cnt++; $display("FAIL rst_busy_done: got %b want 00", {a_busy, a_done}); end
    vec_cnt++; if (b_cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_b_cmd_ready: got %b want 0", b_cmd_ready); end
    rst_n = 1'b1;
    tick();
    vec_cnt++; if (a_cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rel_cmd_ready: got %b want 1", a_cmd_ready); end
    vec_cnt++; if (b_cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rel_b_cmd_ready: got %b want 1", b_cmd_ready); end
  endtask

  task automatic test_single_lane();
    logic [15:0] ex [4];
    logic [15:0] ey [4];
    ex[0] = 16'd0; ey[0] = 16'd0; ex[1] = 16'd1; ey[1] = 16'd0;
    ex[2] = 16'd0; ey[2] = 16'd1; ex[3] = 16'd1; ey[3] = 16'd1;
    a_req_ready = 1'b1;
    launch_a(16'd2, 16'd2, 16'd1, 32'h8000_0000, 32'h0000_1000);
    vec_cnt++; if ({a_busy, a_cmd_ready} !== 2'b10) begin err_cnt++; $display("FAIL single_busy_rdy: got %b want 10", {a_busy, a_cmd_ready}); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (a_req_valid !== 1'b1 || a_req_data !== mk(ex[i], ey[i], 16'd0, 32'h8000_0000, 32'h0000_1000)) begin
        err_cnt++; $display("FAIL single_beat[%0d]: got v=%b %h want %h", i, a_req_valid, a_req_data,
                            mk(ex[i], ey[i], 16'd0, 32'h8000_0000, 32'h0000_1000));
      end
      vec_cnt++; if (a_done !== 1'b0) begin err_cnt++; $display("FAIL single_early_done[%0d]: got %b want 0", i, a_done); end
      tick();
    end
    vec_cnt++; if ({a_req_valid, a_done, a_busy} !== 3'b010) begin err_cnt++; $display("FAIL single_end: got v/done/busy=%b want 010", {a_req_valid, a_done, a_busy}); end
    tick();
    vec_cnt++; if ({a_done, a_cmd_ready} !== 2'b01) begin err_cnt++; $display("FAIL single_idle: got done/rdy=%b want 01", {a_done, a_cmd_ready}); end
  endtask

  task automatic test_partial_beat();
    logic [LW-1:0] e1 [4];
    logic [LW-1:0] e2 [4];
    e1[0] = mk(16'd0, 16'd0, 16'd0, 32'h0000_4000, 32'hDEAD_0000);
    e1[1] = mk(16'd1, 16'd0, 16'd0, 32'h0000_4000, 32'hDEAD_0000);
    e1[2] = mk(16'd2, 16'd0, 16'd0, 32'h0000_4000, 32'hDEAD_0000);
    e1[3] = mk(16'd0, 16'd0, 16'd1, 32'h0000_4000, 32'hDEAD_0000);
    e2[0] = mk(16'd1, 16'd0, 16'd1, 32'h0000_4000, 32'hDEAD_0000);
    e2[1] = mk(16'd2, 16'd0, 16'd1, 32'h0000_4000, 32'hDEAD_0000);
    e2[2] = '0;
    e2[3] = '0;
    b_req_ready = 1'b1;
    b_cmd_valid = 1'b1; b_gx = 16'd3; b_gy = 16'd1; b_gz = 16'd2; b_pc = 32'h0000_4000; b_arg = 32'hDEAD_0000;
    tick();
    b_cmd_valid = 1'b0;
    vec_cnt++; if (b_req_valid !== 1'b1) begin err_cnt++; $display("FAIL partial_v1: got %b want 1", b_req_valid); end
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if (b_req_data[k*LW +: LW] !== e1[k]) begin err_cnt++; $display("FAIL partial_b1_lane%0d: got %h want %h", k, b_req_data[k*LW +: LW], e1[k]); end
    end
    tick();
    vec_cnt++; if (b_req_valid !== 1'b1) begin err_cnt++; $display("FAIL partial_v2: got %b want 1", b_req_valid); end
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if (b_req_data[k*LW +: LW] !== e2[k]) begin err_cnt++; $display("FAIL partial_b2_lane%0d: got %h want %h", k, b_req_data[k*LW +: LW], e2[k]); end
    end
    tick();
    vec_cnt++; if ({b_req_valid, b_done} !== 2'b01) begin err_cnt++; $display("FAIL partial_end: got v/done=%b want 01", {b_req_valid, b_done}); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] held;
    logic          stalled;
    logic          rdy;
    logic          fin;
    int            nacc;
    stalled = 1'b0; rdy = 1'b0; fin = 1'b0; nacc = 0; held = '0;
    a_req_ready = 1'b0;
    launch_a(16'd5, 16'd1, 16'd1, 32'h0000_2000, 32'h0000_0040);
    for (int c = 0; c < 40; c++) begin
      if (!fin) begin
        if (stalled) begin
          vec_cnt++;
          if (a_req_valid !== 1'b1 || a_req_data !== held) begin err_cnt++; $display("FAIL bp_stable[%0d]: got v=%b %h want %h", c, a_req_valid, a_req_data, held); end
        end
        if (a_req_valid === 1'b1) begin
          a_req_ready = rdy;
          if (rdy) begin
            vec_cnt++;
            if (a_req_data !== mk(nacc[15:0], 16'd0, 16'd0, 32'h0000_2000, 32'h0000_0040)) begin
              err_cnt++; $display("FAIL bp_beat[%0d]: got %h want %h", nacc, a_req_data, mk(nacc[15:0], 16'd0, 16'd0, 32'h0000_2000, 32'h0000_0040));
            end
            nacc++;
            stalled = 1'b0;
          end else begin
            held = a_req_data;
            stalled = 1'b1;
          end
        end else begin
          fin = 1'b1;
          vec_cnt++; if (a_done !== 1'b1) begin err_cnt++; $display("FAIL bp_done: got %b want 1", a_done); end
        end
        rdy = ~rdy;
        tick();
      end
    end
    vec_cnt++; if (fin !== 1'b1) begin err_cnt++; $display("FAIL bp_timeout: got finished=%b want 1", fin); end
    vec_cnt++; if (nacc != 5) begin err_cnt++; $display("FAIL bp_count: got %0d want 5", nacc); end
    a_req_ready = 1'b1;
    tick();
  endtask

  task automatic test_zero_dim();
    vec_cnt++; if (a_cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL zero_pre_rdy: got %b want 1", a_cmd_ready); end
    launch_a(16'd4, 16'd0, 16'd3, 32'h0000_3000, 32'h0000_0080);
    vec_cnt++; if ({a_req_valid, a_done, a_busy} !== 3'b000) begin err_cnt++; $display("FAIL zero_c1: got v/done/busy=%b want 000", {a_req_valid, a_done, a_busy}); end
    tick();
    vec_cnt++; if ({a_req_valid, a_done} !== 2'b01) begin err_cnt++; $display("FAIL zero_c2: got v/done=%b want 01", {a_req_valid, a_done}); end
    tick();
    vec_cnt++; if ({a_req_valid, a_done, a_cmd_ready} !== 3'b001) begin err_cnt++; $display("FAIL zero_c3: got v/done/rdy=%b want 001", {a_req_valid, a_done, a_cmd_ready}); end
  endtask

  task automatic test_cancel();
    a_req_ready = 1'b1;
    launch_a(16'd10, 16'd1, 16'd1, 32'h0000_5000, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (a_req_data !== mk(i[15:0], 16'd0, 16'd0, 32'h0000_5000, 32'h0000_0100)) begin err_cnt++; $display("FAIL cancel_pre[%0d]: got %h", i, a_req_data); end
      tick();
    end
    a_req_ready = 1'b0;
    tick();
    a_cancel = 1'b1;
    tick();
    a_cancel = 1'b0;
    vec_cnt++;
    if (a_req_valid !== 1'b1 || a_req_data !== mk(16'd3, 16'd0, 16'd0, 32'h0000_5000, 32'h0000_0100)) begin
      err_cnt++; $display("FAIL cancel_hold: got v=%b %h want x=3 beat", a_req_valid, a_req_data);
    end
    a_req_ready = 1'b1;
    tick();
    vec_cnt++; if ({a_req_valid, a_done} !== 2'b01) begin err_cnt++; $display("FAIL cancel_end: got v/done=%b want 01 (data %h)", {a_req_valid, a_done}, a_req_data); end
    tick();
    vec_cnt++; if ({a_req_valid, a_cmd_ready} !== 2'b01) begin err_cnt++; $display("FAIL cancel_idle: got v/rdy=%b want 01", {a_req_valid, a_cmd_ready}); end
  endtask

  task automatic test_async_reset();
    a_req_ready = 1'b0;
    launch_a(16'd10, 16'd1, 16'd1, 32'h0000_6000, 32'h0000_0200);
    vec_cnt++; if ({a_req_valid, a_busy} !== 2'b11) begin err_cnt++; $display("FAIL ar_pre: got v/busy=%b want 11", {a_req_valid, a_busy}); end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if ({a_req_valid, a_busy, a_done} !== 3'b000) begin err_cnt++; $display("FAIL ar_drop: got v/busy/done=%b want 000", {a_req_valid, a_busy, a_done}); end
    vec_cnt++; if (a_cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL ar_rdy_low: got %b want 0", a_cmd_ready); end
    #1;
    rst_n = 1'b1;
    tick();
    vec_cnt++; if ({a_cmd_ready, a_req_valid} !== 2'b10) begin err_cnt++; $display("FAIL ar_release: got rdy/v=%b want 10", {a_cmd_ready, a_req_valid}); end
    a_req_ready = 1'b1;
    launch_a(16'd1, 16'd1, 16'd1, 32'h0000_0100, 32'h0000_0200);
    vec_cnt++;
    if (a_req_valid !== 1'b1 || a_req_data !== mk(16'd0, 16'd0, 16'd0, 32'h0000_0100, 32'h0000_0200)) begin
      err_cnt++; $display("FAIL ar_new_beat: got v=%b %h", a_req_valid, a_req_data);
    end
    tick();
    vec_cnt++; if ({a_req_valid, a_done} !== 2'b01) begin err_cnt++; $display("FAIL ar_new_done: got v/done=%b want 01", {a_req_valid, a_done}); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_cnt = 0; err_cnt = 0;
    rst_n = 1'b0;
    a_cmd_valid = 1'b0; a_cancel = 1'b0; a_req_ready = 1'b0;
    a_gx = 16'd0; a_gy = 16'd0; a_gz = 16'd0; a_pc = 32'd0; a_arg = 32'd0;
    b_cmd_valid = 1'b0; b_cancel = 1'b0; b_req_ready = 1'b0;
    b_gx = 16'd0; b_gy = 16'd0; b_gz = 16'd0; b_pc = 32'd0; b_arg = 32'd0;
    test_reset();
    test_single_lane();
    test_partial_beat();
    test_backpressure();
    test_zero_dim();
    test_cancel();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
